// File: rtl/wb_regfile.sv
// Write-back mux, 32-entry register file with same-cycle write-through read ports,
// and a registered copy of the last committed write for the forwarding unit.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_WB_control,
  input  logic [ADDR_W-1:0] i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [DATA_W-1:0] i_result,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_last_reg,
  output logic [DATA_W-1:0] o_last_data,
  output logic              o_last_valid
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [ADDR_W-1:0] last_reg_q;
  logic [DATA_W-1:0] last_data_q;
  logic              last_valid_q;

  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  assign wb_data = i_WB_control[0] ? i_write_data : i_result;
  assign wb_we   = i_WB_control[1] & (i_write_reg != '0);

  // NOTE: the array is cleared by the async reset because reads must return 0
  // after reset; this forces flops rather than a RAM macro, which is intended.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      // NOTE: non-blocking so every read this cycle sees the pre-edge contents.
      regs_q[i_write_reg] <= wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_reg_q   <= '0;
      last_data_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_valid_q <= wb_we;
      if (wb_we) begin
        last_reg_q  <= i_write_reg;
        last_data_q <= wb_data;
      end
    end
  end

  // r0 wins over the bypass, so a stray write to r0 can never leak through.
  always_comb begin
    o_rs_data = regs_q[i_rs];
    if (i_rs == '0) begin
      o_rs_data = '0;
    end else if (wb_we && (i_rs == i_write_reg)) begin
      o_rs_data = wb_data;
    end
  end

  always_comb begin
    o_rt_data = regs_q[i_rt];
    if (i_rt == '0) begin
      o_rt_data = '0;
    end else if (wb_we && (i_rt == i_write_reg)) begin
      o_rt_data = wb_data;
    end
  end

  assign o_wb_data    = wb_data;
  assign o_wb_we      = wb_we;
  assign o_last_reg   = last_reg_q;
  assign o_last_data  = last_data_q;
  assign o_last_valid = last_valid_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued as stimulus is applied
// and compared against the outputs on the falling edge (or mid-cycle for async reset).
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [1:0]        wb_control;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] last_data;
  logic              last_valid;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_WB_control (wb_control),
    .i_write_reg  (write_reg),
    .i_write_data (write_data),
    .i_result     (result),
    .i_rs         (rs),
    .i_rt         (rt),
    .o_rs_data    (rs_data),
    .o_rt_data    (rt_data),
    .o_wb_data    (wb_data),
    .o_wb_we      (wb_we),
    .o_last_reg   (last_reg),
    .o_last_data  (last_data),
    .o_last_valid (last_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { SEL_RS, SEL_RT, SEL_WB_DATA, SEL_WB_WE,
                     SEL_LAST_REG, SEL_LAST_DATA, SEL_LAST_VALID } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      SEL_RS:         return rs_data;
      SEL_RT:         return rt_data;
      SEL_WB_DATA:    return wb_data;
      SEL_WB_WE:      return {31'd0, wb_we};
      SEL_LAST_REG:   return {27'd0, last_reg};
      SEL_LAST_DATA:  return last_data;
      default:        return {31'd0, last_valid};
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Advance to just after the next rising edge, where new stimulus is applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [31:0] res,
                       input logic [4:0] a, input logic [4:0] b);
    wb_control = ctl;
    write_reg  = wr;
    write_data = wd;
    result     = res;
    rs         = a;
    rt         = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 5'd1, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 5'd0, 5'd0);

    // Reset held: every register reads 0, last-write copy is cleared.
    for (int r = 1; r < 32; r++) begin
      rs = 5'(r);
      rt = 5'(32 - r);
      #1;
      expect_val($sformatf("reset_rs_r%0d", r), SEL_RS, 32'h0);
      expect_val($sformatf("reset_rt_r%0d", 32 - r), SEL_RT, 32'h0);
      drain();
    end
    expect_val("reset_last_valid", SEL_LAST_VALID, 32'h0);
    expect_val("reset_last_reg", SEL_LAST_REG, 32'h0);
    expect_val("reset_last_data", SEL_LAST_DATA, 32'h0);
    drain();

    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to r5, read back next cycle.
    step();
    drive(2'b10, 5'd5, 32'h0, 32'hDEAD_BEEF, 5'd1, 5'd2);
    expect_val("alu_wb_we", SEL_WB_WE, 32'h1);
    expect_val("alu_wb_data", SEL_WB_DATA, 32'hDEAD_BEEF);
    sample();
    step();
    drive(2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd6);
    expect_val("alu_read_r5", SEL_RS, 32'hDEAD_BEEF);
    expect_val("alu_read_r6", SEL_RT, 32'h0);
    expect_val("alu_last_valid", SEL_LAST_VALID, 32'h1);
    expect_val("alu_last_reg", SEL_LAST_REG, 32'd5);
    expect_val("alu_last_data", SEL_LAST_DATA, 32'hDEAD_BEEF);
    sample();

    // Load path with both ports bypassing the same register.
    step();
    drive(2'b11, 5'd7, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7, 5'd7);
    expect_val("load_wb_data", SEL_WB_DATA, 32'h1234_5678);
    expect_val("load_bypass_rs", SEL_RS, 32'h1234_5678);
    expect_val("load_bypass_rt", SEL_RT, 32'h1234_5678);
    sample();
    step();
    drive(2'b00, 5'd7, 32'h0, 32'h0, 5'd7, 5'd5);
    expect_val("load_commit_r7", SEL_RS, 32'h1234_5678);
    expect_val("load_keep_r5", SEL_RT, 32'hDEAD_BEEF);
    sample();

    // Write to r0 is discarded, including through the bypass.
    step();
    drive(2'b10, 5'd0, 32'h0, 32'hAAAA_5555, 5'd0, 5'd0);
    expect_val("r0_wb_we", SEL_WB_WE, 32'h0);
    expect_val("r0_wb_data", SEL_WB_DATA, 32'hAAAA_5555);
    expect_val("r0_bypass_rs", SEL_RS, 32'h0);
    sample();
    step();
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7);
    expect_val("r0_after_rs", SEL_RS, 32'h0);
    expect_val("r0_last_valid", SEL_LAST_VALID, 32'h0);
    expect_val("r0_last_reg_hold", SEL_LAST_REG, 32'd7);
    expect_val("r0_last_data_hold", SEL_LAST_DATA, 32'h1234_5678);
    sample();

    // RegWrite=0: mux still active, nothing commits, last-write data holds.
    step();
    drive(2'b10, 5'd3, 32'h0, 32'h0000_0001, 5'd0, 5'd0);
    step();
    drive(2'b01, 5'd3, 32'h0000_0099, 32'h0, 5'd3, 5'd3);
    expect_val("nowr_wb_data", SEL_WB_DATA, 32'h0000_0099);
    expect_val("nowr_wb_we", SEL_WB_WE, 32'h0);
    expect_val("nowr_no_bypass", SEL_RS, 32'h0000_0001);
    expect_val("preload_last_valid", SEL_LAST_VALID, 32'h1);
    sample();
    step();
    drive(2'b00, 5'd3, 32'h0, 32'h0, 5'd3, 5'd0);
    expect_val("nowr_r3_kept", SEL_RS, 32'h0000_0001);
    expect_val("nowr_last_valid", SEL_LAST_VALID, 32'h0);
    expect_val("nowr_last_reg", SEL_LAST_REG, 32'd3);
    expect_val("nowr_last_data", SEL_LAST_DATA, 32'h0000_0001);
    sample();

    // Top register with independent ports: one bypasses, one does not.
    step();
    drive(2'b10, 5'd31, 32'h0, 32'h0000_0031, 5'd31, 5'd30);
    expect_val("r31_bypass_rs", SEL_RS, 32'h0000_0031);
    expect_val("r30_no_bypass_rt", SEL_RT, 32'h0);
    sample();
    step();
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd31, 5'd3);
    expect_val("r31_commit", SEL_RS, 32'h0000_0031);
    expect_val("r3_unaffected", SEL_RT, 32'h0000_0001);
    sample();

    // Async reset mid-run, between clock edges.
    step();
    drive(2'b10, 5'd9, 32'h0, 32'h0000_CAFE, 5'd0, 5'd0);
    step();
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd31);
    expect_val("pre_rst_r9", SEL_RS, 32'h0000_CAFE);
    expect_val("pre_rst_last_valid", SEL_LAST_VALID, 32'h1);
    sample();
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_r9", SEL_RS, 32'h0);
    expect_val("async_rst_r31", SEL_RT, 32'h0);
    expect_val("async_rst_last_valid", SEL_LAST_VALID, 32'h0);
    expect_val("async_rst_last_reg", SEL_LAST_REG, 32'h0);
    expect_val("async_rst_last_data", SEL_LAST_DATA, 32'h0);
    drain();
    #1;
    rst_n = 1'b1;
    step();
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7);
    expect_val("post_rst_r5", SEL_RS, 32'h0);
    expect_val("post_rst_r7", SEL_RT, 32'h0);
    sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
